eq1_bus_master: RTL and testbench

//  Initiator for the 4-register shared-bus slave (ce/rw/address/bidirectional data, slave acts on negedge clock).

---
 rtl/eq1_bus_master_if.sv | 25 ++
 rtl/eq1_bus_master.sv | 75 +++++++
 tb/tb_eq1_bus_master.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/eq1_bus_master_if.sv
// Host-side request/acknowledge bundle for eq1_bus_master.
// The host drives through the master modport; the bus master consumes it through the slave modport.
interface eq1_bus_master_if #(
    parameter int D_SIZE = 7,
    parameter int A_SIZE = 1
);
    logic              req;
    logic              we;
    logic [A_SIZE:0]   addr;
    logic [D_SIZE:0]   wdata;
    logic              ready;
    logic              done;
    logic [D_SIZE:0]   rdata;

    // Handshake: a request is taken on a posedge where req && ready; done pulses one cycle at completion.
    modport master (
        output req, we, addr, wdata,
        input  ready, done, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output ready, done, rdata
    );
endinterface

// File: rtl/eq1_bus_master.sv
// Initiator for the 4-register shared bus: turns one host request into a write or read bus cycle,
// then holds ce low for one turnaround cycle so master and slave never drive data together.
module eq1_bus_master #(
    parameter int D_SIZE = 7,
    parameter int A_SIZE = 1
) (
    input  logic               clock,
    input  logic               reset_n,
    eq1_bus_master_if.slave    host,
    inout  wire  [D_SIZE:0]    bus_data,
    output logic [A_SIZE:0]    bus_address,
    output logic               bus_rw,
    output logic               bus_ce,
    output logic [1:0]         dbg_state
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        TURN  = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic            data_oe;
    logic [D_SIZE:0] data_out;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (host.req) state_nx = host.we ? WRITE : READ;
            WRITE:   state_nx = TURN;
            READ:    state_nx = TURN;
            TURN:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Bus outputs are registered from the next state so they are settled before the slave's negedge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bus_ce      <= 1'b0;
            bus_rw      <= 1'b0;
            bus_address <= '0;
            data_oe     <= 1'b0;
            data_out    <= '0;
            host.done   <= 1'b0;
            host.rdata  <= '0;
        end else begin
            bus_ce    <= (state_nx == WRITE) || (state_nx == READ);
            data_oe   <= (state_nx == WRITE);
            host.done <= (state == TURN);
            if (state == IDLE && host.req) begin
                bus_rw      <= host.we;
                bus_address <= host.addr;
                data_out    <= host.wdata;
            end
            if (state == READ) begin
                host.rdata <= bus_data;
            end
        end
    end

    assign bus_data   = data_oe ? data_out : 'z;
    assign host.ready = (state == IDLE);
    assign dbg_state  = state;
endmodule

// File: tb/tb_eq1_bus_master.sv
// Bench for eq1_bus_master: 4-register negedge slave on the bus, memory reference model,
// directed scenarios followed by randomized transactions.
module tb_eq1_bus_master;
    logic       clock;
    logic       reset_n;
    wire  [7:0] bus_data;
    logic [1:0] bus_address;
    logic       bus_rw;
    logic       bus_ce;
    logic [1:0] dbg_state;

    eq1_bus_master_if #(.D_SIZE(7), .A_SIZE(1)) hif ();

    eq1_bus_master #(.D_SIZE(7), .A_SIZE(1)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .host        (hif.slave),
        .bus_data    (bus_data),
        .bus_address (bus_address),
        .bus_rw      (bus_rw),
        .bus_ce      (bus_ce),
        .dbg_state   (dbg_state)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // bus slave: four registers, acts on negedge
    logic [7:0] sregs [4];
    logic       s_oe;
    logic [7:0] s_dout;
    assign bus_data = s_oe ? s_dout : 'z;

    always @(negedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) sregs[i] <= 8'h00;
            s_oe   <= 1'b0;
            s_dout <= 8'h00;
        end else begin
            if (bus_ce && bus_rw) sregs[bus_address] <= bus_data;
            if (bus_ce && !bus_rw) begin
                s_oe   <= 1'b1;
                s_dout <= sregs[bus_address];
            end else begin
                s_oe <= 1'b0;
            end
        end
    end

    // scoreboard and reference model
    int         total = 0;
    int         bad   = 0;
    logic [7:0] mem [4];
    logic [7:0] exp_q [$];
    logic [7:0] last_rdata;
    bit         hold_mode;
    bit         have_prev;
    int         prev_acc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // master and slave must never drive the data bus in the same cycle
    always @(posedge clock) begin
        #1;
        if (reset_n) chk("contention", {31'd0, s_oe && bus_ce && bus_rw}, 32'd0);
    end

    task automatic model_reset();
        for (int i = 0; i < 4; i++) mem[i] = 8'h00;
        exp_q.delete();
        last_rdata = 8'h00;
        have_prev  = 1'b0;
    endtask

    // driver: called at a negedge, returns at the negedge where done is checked
    task automatic txn(input bit w, input logic [1:0] a, input logic [7:0] d);
        int waited = 0;
        int acc;
        hif.req = 1'b1; hif.we = w; hif.addr = a; hif.wdata = d;
        while (!hif.ready && waited < 10) begin
            @(negedge clock);
            waited++;
        end
        if (!hif.ready) begin
            chk("ready_timeout", 32'd0, 32'd1);
            hif.req = 1'b0;
            return;
        end
        acc = cyc;
        if (hold_mode && have_prev) chk("accept_spacing", acc - prev_acc, 32'd3);
        prev_acc  = acc;
        have_prev = 1'b1;
        if (w) mem[a] = d;
        else exp_q.push_back(mem[a]);
        @(negedge clock);
        if (!hold_mode) hif.req = 1'b0;
        chk("ready_k0", {31'd0, hif.ready}, 32'd0);
        chk("done_k0", {31'd0, hif.done}, 32'd0);
        chk("bus_ce_active", {31'd0, bus_ce}, 32'd1);
        chk("bus_rw", {31'd0, bus_rw}, {31'd0, w});
        chk("bus_address", {30'd0, bus_address}, {30'd0, a});
        @(negedge clock);
        chk("ready_k1", {31'd0, hif.ready}, 32'd0);
        chk("done_k1", {31'd0, hif.done}, 32'd0);
        chk("bus_ce_turn", {31'd0, bus_ce}, 32'd0);
        @(negedge clock);
        chk("ready_k2", {31'd0, hif.ready}, 32'd1);
        chk("done_k2", {31'd0, hif.done}, 32'd1);
        if (!w) begin
            if (exp_q.size() > 0) begin
                last_rdata = exp_q.pop_front();
                chk("rdata", {24'd0, hif.rdata}, {24'd0, last_rdata});
            end
        end else begin
            chk("rdata_hold", {24'd0, hif.rdata}, {24'd0, last_rdata});
        end
    endtask

    task automatic reset_mid_read();
        hif.req = 1'b1; hif.we = 1'b0; hif.addr = 2'd1;
        @(posedge clock);
        #2;
        hif.req = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("rst_bus_ce", {31'd0, bus_ce}, 32'd0);
        chk("rst_bus_rw", {31'd0, bus_rw}, 32'd0);
        chk("rst_bus_addr", {30'd0, bus_address}, 32'd0);
        chk("rst_done", {31'd0, hif.done}, 32'd0);
        chk("rst_rdata", {24'd0, hif.rdata}, 32'd0);
        chk("rst_state", {30'd0, dbg_state}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("rst_no_done", {31'd0, hif.done}, 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b1;
        hif.req = 1'b0; hif.we = 1'b0; hif.addr = 2'd0; hif.wdata = 8'd0;
        hold_mode = 1'b0;
        model_reset();
        #3 reset_n = 1'b0;
        #1;
        chk("init_bus_ce", {31'd0, bus_ce}, 32'd0);
        chk("init_bus_rw", {31'd0, bus_rw}, 32'd0);
        chk("init_done", {31'd0, hif.done}, 32'd0);
        chk("init_rdata", {24'd0, hif.rdata}, 32'd0);
        chk("init_ready", {31'd0, hif.ready}, 32'd1);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);

        // write then read back
        txn(1'b1, 2'd2, 8'hA5);
        txn(1'b0, 2'd2, 8'h00);

        // fill all registers, read back out of order
        txn(1'b1, 2'd0, 8'h11);
        txn(1'b1, 2'd1, 8'h22);
        txn(1'b1, 2'd2, 8'h33);
        txn(1'b1, 2'd3, 8'h44);
        txn(1'b0, 2'd3, 8'h00);
        txn(1'b0, 2'd0, 8'h00);
        txn(1'b0, 2'd2, 8'h00);
        txn(1'b0, 2'd1, 8'h00);

        // read immediately followed by write to the same register
        txn(1'b0, 2'd1, 8'h00);
        txn(1'b1, 2'd1, 8'h5A);
        txn(1'b0, 2'd1, 8'h00);

        // req held high with alternating direction
        hold_mode = 1'b1;
        have_prev = 1'b0;
        for (int i = 0; i < 6; i++) txn(i[0] == 1'b0, i[1:0], 8'h30 + 8'(i));
        hold_mode = 1'b0;
        hif.req = 1'b0;
        @(negedge clock);

        // reset during a read, then normal traffic
        reset_mid_read();
        txn(1'b1, 2'd0, 8'h00);
        txn(1'b1, 2'd3, 8'hFF);
        txn(1'b0, 2'd0, 8'h00);
        txn(1'b1, 2'd2, 8'h77);
        txn(1'b0, 2'd3, 8'h00);

        // randomized traffic
        for (int i = 0; i < 30; i++) begin
            hold_mode = ($urandom_range(0, 3) == 0);
            have_prev = 1'b0;
            txn($urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
            if (!hold_mode || $urandom_range(0, 1) == 1) begin
                hif.req = 1'b0;
                repeat ($urandom_range(0, 2)) @(negedge clock);
            end
        end
        hold_mode = 1'b0;
        hif.req = 1'b0;
        repeat (3) @(negedge clock);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
